// File: rtl/alu_issue_stage_if.sv
// Handshake and payload bundle between decode, the ALU issue stage and the ALU.
// The stage connects through the slave modport; the decode/ALU side uses the master modport.
interface alu_issue_stage_if #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) ();
    // Upstream (decode) side
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic [RD_W-1:0] rd;

    // Downstream (ALU / branch / writeback) side
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [RD_W-1:0] out_rd;
    logic [XLEN-1:0] out_pc;
    logic            is_branch;
    logic            take_on_zero;
    logic            illegal;

    modport slave (
        input  flush, in_valid, opcode, funct3, funct7_5, pc, rs1, rs2, imm, rd,
        input  out_ready,
        output in_ready,
        output out_valid, alu_op, alu_a, alu_b, out_rd, out_pc,
        output is_branch, take_on_zero, illegal
    );

    modport master (
        output flush, in_valid, opcode, funct3, funct7_5, pc, rs1, rs2, imm, rd,
        output out_ready,
        input  in_ready,
        input  out_valid, alu_op, alu_a, alu_b, out_rd, out_pc,
        input  is_branch, take_on_zero, illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Execute-issue stage: decodes opcode/funct into an ALU op plus operands and
// holds the decoded payload in a 2-entry skid buffer whose head drives the ALU.
module alu_issue_stage #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_issue_stage_if.slave   bus
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_SUM  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b1000;
    localparam logic [3:0] ALU_SUB  = 4'b1010;
    localparam logic [3:0] ALU_GE   = 4'b1100;
    localparam logic [3:0] ALU_GEU  = 4'b1101;
    localparam logic [3:0] ALU_SLT  = 4'b1110;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    typedef struct packed {
        logic [3:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [RD_W-1:0] rd;
        logic [XLEN-1:0] pc;
        logic            br;
        logic            toz;
        logic            ill;
    } entry_t;

    // Shared funct3 table for OP and OP-IMM; alt selects SUB / SRA.
    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_SUM;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    entry_t dec;

    always_comb begin
        dec     = '0;
        dec.op  = ALU_SUM;
        dec.rd  = bus.rd;
        dec.pc  = bus.pc;
        case (bus.opcode)
            OPC_OP: begin
                dec.op = arith_op(bus.funct3, bus.funct7_5);
                dec.a  = bus.rs1;
                dec.b  = bus.rs2;
            end
            OPC_OP_IMM: begin
                // Immediate forms have no SUB; bit 30 only distinguishes SRAI from SRLI.
                dec.op = arith_op(bus.funct3, bus.funct7_5 & (bus.funct3 == 3'b101));
                dec.a  = bus.rs1;
                dec.b  = bus.imm;
            end
            OPC_BRANCH: begin
                dec.a  = bus.rs1;
                dec.b  = bus.rs2;
                dec.br = 1'b1;
                case (bus.funct3)
                    3'b000: begin
                        dec.op  = ALU_SUB;
                        dec.toz = 1'b1;
                    end
                    3'b001:  dec.op  = ALU_SUB;
                    3'b100:  dec.op  = ALU_SLT;
                    3'b101:  dec.op  = ALU_GE;
                    3'b110:  dec.op  = ALU_SLTU;
                    3'b111:  dec.op  = ALU_GEU;
                    default: dec.ill = 1'b1;
                endcase
            end
            OPC_LOAD, OPC_STORE, OPC_JALR: begin
                dec.a = bus.rs1;
                dec.b = bus.imm;
            end
            OPC_JAL, OPC_AUIPC: begin
                dec.a = bus.pc;
                dec.b = bus.imm;
            end
            OPC_LUI: begin
                dec.b = bus.imm;
            end
            default: begin
                dec.ill = 1'b1;
            end
        endcase
    end

    logic [1:0] count_reg;
    logic [1:0] count_next;
    logic       in_ready_reg;
    logic       accept;
    logic       retire;
    entry_t     entry_reg [2];
    entry_t     wr_data   [2];
    logic       wr_en     [2];

    assign accept = bus.in_valid & in_ready_reg;
    assign retire = (count_reg != 2'd0) & bus.out_ready;

    always_comb begin
        count_next = count_reg;
        if (bus.flush) begin
            count_next = 2'd0;
        end else begin
            case ({accept, retire})
                2'b10:   count_next = count_reg + 2'd1;
                2'b01:   count_next = count_reg - 2'd1;
                default: count_next = count_reg;
            endcase
        end
    end

    // Entry 0 is always the head: it shifts from entry 1 on retire when full,
    // or takes the new instruction when it would otherwise be empty.
    always_comb begin
        wr_en[0]   = 1'b0;
        wr_en[1]   = 1'b0;
        wr_data[0] = dec;
        wr_data[1] = dec;
        if (!bus.flush) begin
            if (retire && count_reg == 2'd2) begin
                wr_en[0]   = 1'b1;
                wr_data[0] = entry_reg[1];
            end else if (accept && (count_reg == 2'd0 || (count_reg == 2'd1 && retire))) begin
                wr_en[0] = 1'b1;
            end
            if (accept && count_reg == 2'd1 && !retire) begin
                wr_en[1] = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg[gi] <= '0;
                end else if (wr_en[gi]) begin
                    entry_reg[gi] <= wr_data[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg    <= 2'd0;
            in_ready_reg <= 1'b0;
        end else begin
            count_reg    <= count_next;
            in_ready_reg <= (count_next != 2'd2);
        end
    end

    assign bus.in_ready     = in_ready_reg;
    assign bus.out_valid    = (count_reg != 2'd0);
    assign bus.alu_op       = entry_reg[0].op;
    assign bus.alu_a        = entry_reg[0].a;
    assign bus.alu_b        = entry_reg[0].b;
    assign bus.out_rd       = entry_reg[0].rd;
    assign bus.out_pc       = entry_reg[0].pc;
    assign bus.is_branch    = entry_reg[0].br;
    assign bus.take_on_zero = entry_reg[0].toz;
    assign bus.illegal      = entry_reg[0].ill;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed decode vectors, backpressure,
// flush and mid-stream reset; a negedge monitor checks every retired entry.
module tb_alu_issue_stage;
    logic clk;
    logic rst_n;

    alu_issue_stage_if #(.XLEN(32), .RD_W(5)) bus ();

    alu_issue_stage #(.XLEN(32), .RD_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        br;
        logic        toz;
        logic        ill;
    } exp_t;

    typedef struct packed {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        br;
        logic        toz;
        logic        ill;
    } vec_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    function automatic exp_t actual();
        exp_t e;
        e = {bus.alu_op, bus.alu_a, bus.alu_b, bus.out_rd, bus.out_pc,
             bus.is_branch, bus.take_on_zero, bus.illegal};
        return e;
    endfunction

    // Monitor: every handshake that retires an entry is compared against the queue head.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready && !bus.flush) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out: got %h required none", actual());
            end else begin
                check("retire", 128'(actual()), 128'(exp_q.pop_front()));
            end
        end
    end

    task automatic add(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                       input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [4:0] rd, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic br, input logic toz, input logic ill);
        vec_t v;
        v = {opc, f3, f7, pc, rs1, rs2, imm, rd, op, a, b, br, toz, ill};
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        bus.opcode   = v.opc;
        bus.funct3   = v.f3;
        bus.funct7_5 = v.f7;
        bus.pc       = v.pc;
        bus.rs1      = v.rs1;
        bus.rs2      = v.rs2;
        bus.imm      = v.imm;
        bus.rd       = v.rd;
        bus.in_valid = 1'b1;
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic push(input vec_t v);
        int guard;
        drive(v);
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!bus.in_ready) begin
            check("accept_timeout", 128'(bus.in_ready), 128'(1));
            bus.in_valid = 1'b0;
        end else begin
            exp_q.push_back({v.op, v.a, v.b, v.rd, v.pc, v.br, v.toz, v.ill});
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t snap;
        // OP
        add(7'b0110011, 3'b000, 1'b0, 32'h1000, 32'd7, 32'd5, 32'd3, 5'd1,  4'b0010, 32'd7, 32'd5, 0, 0, 0);
        add(7'b0110011, 3'b000, 1'b1, 32'h1004, 32'd7, 32'd5, 32'd3, 5'd2,  4'b1010, 32'd7, 32'd5, 0, 0, 0);
        add(7'b0110011, 3'b001, 1'b0, 32'h1008, 32'd7, 32'd5, 32'd3, 5'd3,  4'b0100, 32'd7, 32'd5, 0, 0, 0);
        add(7'b0110011, 3'b010, 1'b0, 32'h100c, 32'd7, 32'd5, 32'd3, 5'd4,  4'b1110, 32'd7, 32'd5, 0, 0, 0);
        add(7'b0110011, 3'b011, 1'b0, 32'h1010, 32'd7, 32'd5, 32'd3, 5'd5,  4'b1111, 32'd7, 32'd5, 0, 0, 0);
        add(7'b0110011, 3'b100, 1'b0, 32'h1014, 32'd7, 32'd5, 32'd3, 5'd6,  4'b1000, 32'd7, 32'd5, 0, 0, 0);
        add(7'b0110011, 3'b101, 1'b0, 32'h1018, 32'd7, 32'd5, 32'd3, 5'd7,  4'b0101, 32'd7, 32'd5, 0, 0, 0);
        add(7'b0110011, 3'b101, 1'b1, 32'h101c, 32'd7, 32'd5, 32'd3, 5'd8,  4'b0111, 32'd7, 32'd5, 0, 0, 0);
        add(7'b0110011, 3'b110, 1'b0, 32'h1020, 32'd7, 32'd5, 32'd3, 5'd9,  4'b0001, 32'd7, 32'd5, 0, 0, 0);
        add(7'b0110011, 3'b111, 1'b0, 32'h1024, 32'd7, 32'd5, 32'd3, 5'd10, 4'b0000, 32'd7, 32'd5, 0, 0, 0);
        // OP-IMM
        add(7'b0010011, 3'b101, 1'b1, 32'h1028, 32'h80000000, 32'd5, 32'd3, 5'd11, 4'b0111, 32'h80000000, 32'd3, 0, 0, 0);
        add(7'b0010011, 3'b000, 1'b1, 32'h102c, 32'd7, 32'd5, 32'd3, 5'd12, 4'b0010, 32'd7, 32'd3, 0, 0, 0);
        add(7'b0010011, 3'b010, 1'b1, 32'h1030, 32'd7, 32'd5, 32'd3, 5'd13, 4'b1110, 32'd7, 32'd3, 0, 0, 0);
        add(7'b0010011, 3'b001, 1'b1, 32'h1034, 32'd7, 32'd5, 32'd3, 5'd14, 4'b0100, 32'd7, 32'd3, 0, 0, 0);
        // BRANCH
        add(7'b1100011, 3'b000, 1'b0, 32'h1038, 32'd7, 32'd5, 32'd3, 5'd15, 4'b1010, 32'd7, 32'd5, 1, 1, 0);
        add(7'b1100011, 3'b001, 1'b0, 32'h103c, 32'd7, 32'd5, 32'd3, 5'd16, 4'b1010, 32'd7, 32'd5, 1, 0, 0);
        add(7'b1100011, 3'b100, 1'b0, 32'h1040, 32'd7, 32'd5, 32'd3, 5'd17, 4'b1110, 32'd7, 32'd5, 1, 0, 0);
        add(7'b1100011, 3'b101, 1'b0, 32'h1044, 32'd7, 32'd5, 32'd3, 5'd18, 4'b1100, 32'd7, 32'd5, 1, 0, 0);
        add(7'b1100011, 3'b110, 1'b0, 32'h1048, 32'd7, 32'd5, 32'd3, 5'd19, 4'b1111, 32'd7, 32'd5, 1, 0, 0);
        add(7'b1100011, 3'b111, 1'b0, 32'h104c, 32'd7, 32'd5, 32'd3, 5'd20, 4'b1101, 32'd7, 32'd5, 1, 0, 0);
        add(7'b1100011, 3'b010, 1'b0, 32'h1050, 32'd7, 32'd5, 32'd3, 5'd21, 4'b0010, 32'd7, 32'd5, 1, 0, 1);
        // Address forms and illegal opcode
        add(7'b0010111, 3'b000, 1'b0, 32'h1000, 32'd7, 32'd5, 32'h2000, 5'd22, 4'b0010, 32'h1000, 32'h2000, 0, 0, 0);
        add(7'b0110111, 3'b000, 1'b0, 32'h1058, 32'd7, 32'd5, 32'h12345000, 5'd23, 4'b0010, 32'd0, 32'h12345000, 0, 0, 0);
        add(7'b1101111, 3'b000, 1'b0, 32'h105c, 32'd7, 32'd5, 32'h40, 5'd24, 4'b0010, 32'h105c, 32'h40, 0, 0, 0);
        add(7'b0000011, 3'b010, 1'b0, 32'h1060, 32'd7, 32'd5, 32'h10, 5'd25, 4'b0010, 32'd7, 32'h10, 0, 0, 0);
        add(7'b0100011, 3'b010, 1'b0, 32'h1064, 32'd7, 32'd5, 32'hfffffffc, 5'd26, 4'b0010, 32'd7, 32'hfffffffc, 0, 0, 0);
        add(7'b1100111, 3'b000, 1'b0, 32'h1068, 32'd7, 32'd5, 32'h8, 5'd27, 4'b0010, 32'd7, 32'h8, 0, 0, 0);
        add(7'b0000000, 3'b000, 1'b0, 32'h106c, 32'd7, 32'd5, 32'h8, 5'd28, 4'b0010, 32'd0, 32'd0, 0, 0, 1);

        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.opcode    = '0;
        bus.funct3    = '0;
        bus.funct7_5  = 1'b0;
        bus.pc        = '0;
        bus.rs1       = '0;
        bus.rs2       = '0;
        bus.imm       = '0;
        bus.rd        = '0;
        #3;
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_in_ready",  128'(bus.in_ready),  128'(0));
        check("rst_payload",   128'(actual()),      128'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_hold_in_ready", 128'(bus.in_ready), 128'(0));
        cycle();
        check("release_in_ready", 128'(bus.in_ready), 128'(1));

        // Decode table at full throughput; first accept is visible right after its edge.
        bus.out_ready = 1'b1;
        push(vecs[0]);
        check("latency_valid", 128'(bus.out_valid), 128'(1));
        check("latency_op",    128'(bus.alu_op),    128'(4'b0010));
        for (int i = 1; i < vecs.size(); i++) push(vecs[i]);
        drain();

        // Backpressure: two accepts fill the buffer, the third waits with outputs frozen.
        bus.out_ready = 1'b0;
        push(vecs[1]);
        push(vecs[21]);
        check("full_in_ready", 128'(bus.in_ready), 128'(0));
        snap = actual();
        drive(vecs[7]);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_stable",   128'(actual()),     128'(snap));
            check("stall_in_ready", 128'(bus.in_ready), 128'(0));
        end
        bus.out_ready = 1'b1;
        push(vecs[7]);
        drain();

        // Flush with a full buffer and a pending input.
        bus.out_ready = 1'b0;
        push(vecs[14]);
        push(vecs[20]);
        drive(vecs[22]);
        bus.flush = 1'b1;
        cycle();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        check("flush_full_valid", 128'(bus.out_valid), 128'(0));
        check("flush_in_ready",   128'(bus.in_ready),  128'(1));

        // Flush with one entry while an input is actually acceptable.
        push(vecs[3]);
        drive(vecs[5]);
        bus.flush = 1'b1;
        cycle();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        check("flush_drop_valid", 128'(bus.out_valid), 128'(0));
        bus.out_ready = 1'b1;
        cycle();
        cycle();
        check("flush_stays_empty", 128'(bus.out_valid), 128'(0));
        push(vecs[9]);
        drain();

        // Asynchronous reset mid-stream.
        bus.out_ready = 1'b0;
        push(vecs[27]);
        push(vecs[2]);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_out_valid", 128'(bus.out_valid), 128'(0));
        check("midrst_in_ready",  128'(bus.in_ready),  128'(0));
        check("midrst_alu_op",    128'(bus.alu_op),    128'(0));
        check("midrst_payload",   128'(actual()),      128'(0));
        cycle();
        rst_n = 1'b1;
        cycle();
        check("midrst_release_ready", 128'(bus.in_ready),  128'(1));
        check("midrst_release_valid", 128'(bus.out_valid), 128'(0));
        bus.out_ready = 1'b1;
        push(vecs[10]);
        push(vecs[0]);
        drain();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Execute-issue stage directly upstream of the ALU.
- Accepts decoded instruction fields from decode, maps opcode/funct3/funct7 to the 4-bit ALU operation code, selects operands, and buffers the result in a 2-entry skid buffer with valid/ready handshakes.
- Its outputs drive the ALU's ALU_OP_i, ALU_RS1_i and ALU_RS2_i inputs directly, plus branch/writeback sideband for downstream stages.

Parameters:
XLEN, 32, datapath width of PC, RS1, RS2, IMM and operand outputs
RD_W, 5, destination register index width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
FLUSH_i  input  1  synchronous flush: drops all buffered entries
IN_VALID_i  input  1  upstream has an instruction
IN_READY_o  output  1  stage can accept this cycle
OPCODE_i  input  7  instr[6:0]
FUNCT3_i  input  3  instr[14:12]
FUNCT7_5_i  input  1  instr[30]
PC_i  input  XLEN  instruction PC
RS1_i  input  XLEN  rs1 value
RS2_i  input  XLEN  rs2 value
IMM_i  input  XLEN  sign-extended immediate for the instruction format
RD_i  input  RD_W  destination index
OUT_VALID_o  output  1  head entry valid
OUT_READY_i  input  1  downstream accepts head
ALU_OP_o  output  4  ALU operation code
ALU_A_o  output  XLEN  ALU first operand
ALU_B_o  output  XLEN  ALU second operand
RD_o  output  RD_W  destination index
PC_o  output  XLEN  PC pass-through
IS_BRANCH_o  output  1  conditional branch
TAKE_ON_ZERO_o  output  1  branch is taken when ALU zero flag is 1; otherwise taken when it is 0
ILLEGAL_o  output  1  opcode/funct unsupported

Behaviour:
- ALU codes: AND 0000, OR 0001, SUM 0010, EQUAL 0011, SLL 0100, SRL 0101, SRA 0111, XOR 1000, NOR 1001, SUB 1010, GE 1100, GEU 1101, SLT 1110, SLTU 1111.
- OP (0110011): funct3 maps as follows.
  - 000: SUB if FUNCT7_5_i, else SUM.
  - 001: SLL. 010: SLT. 011: SLTU. 100: XOR.
  - 101: SRA if FUNCT7_5_i, else SRL.
  - 110: OR. 111: AND.
  - A=RS1, B=RS2.
- OP-IMM (0010011): same mapping, but funct3=000 is always SUM; FUNCT7_5_i is honoured only for 101. A=RS1, B=IMM.
- BRANCH (1100011): A=RS1, B=RS2, IS_BRANCH=1.
  - 000 SUB, TAKE_ON_ZERO=1.
  - 001 SUB, 100 SLT, 101 GE, 110 SLTU, 111 GEU, all with TAKE_ON_ZERO=0.
  - 010 and 011 are ILLEGAL.
- Address opcodes, all op SUM:
  - LOAD (0000011), STORE (0100011), JALR (1100111): A=RS1, B=IMM.
  - JAL (1101111), AUIPC (0010111): A=PC, B=IMM.
  - LUI (0110111): A=0, B=IMM.
- Any other opcode:
  - ILLEGAL=1, op SUM, A=0, B=0.
  - The entry still flows through the stage; it is not dropped.
- IS_BRANCH=0 and TAKE_ON_ZERO=0 for all non-branch instructions.
- Decode is combinational on the inputs; the decoded payload is what gets stored.
- Buffer: 2 entries, FIFO order; head drives all outputs.
  - IN_READY_o is registered and equals (count<2).
  - Accept when IN_VALID_i & IN_READY_o.
  - Retire when OUT_VALID_o & OUT_READY_i.
- Latency: an instruction accepted at edge N is visible on the outputs after edge N (zero bubbles when the buffer is empty).
- Full throughput: with OUT_READY_i held at 1, one instruction per cycle.
- Simultaneous accept and retire: count unchanged; order preserved.
  - count=2 blocks accept even if retire occurs the same cycle.
- OUT_VALID_o=0: payload outputs hold their last value; no requirement on contents.
- Stall: while OUT_VALID_o & ~OUT_READY_i, all payload outputs are stable.
- FLUSH_i has priority over accept and retire: next cycle count=0 and OUT_VALID_o=0; an input presented in the flush cycle is discarded.
- Reset (async assert, sync release):
  - count=0, OUT_VALID_o=0, IN_READY_o=0 while rst_n=0, IN_READY_o=1 on the first edge after release.
  - All payload registers = 0, so ALU_OP_o=0000 and ILLEGAL_o=0.
  - Reset mid-operation discards all entries.

Test Plan:
- ADD then SUB: OPCODE=0110011 f3=000 f7_5=0/1, RS1=7, RS2=5 -> ALU_OP=0010 then 1010, A=7, B=5, one cycle after each accept.
- SRAI/ADDI: OPCODE=0010011 f3=101 f7_5=1 IMM=3 -> op 0111, B=3; f3=000 f7_5=1 -> op 0010 (not SUB).
- Branches: BEQ -> op 1010, TAKE_ON_ZERO=1; BGEU -> op 1101, TAKE_ON_ZERO=0; f3=010 -> ILLEGAL=1.
- AUIPC PC=0x1000 IMM=0x2000 -> A=0x1000, B=0x2000, op 0010; LUI -> A=0; OPCODE=0000000 -> ILLEGAL=1, A=B=0.
- Backpressure: OUT_READY=0, push 3 -> IN_READY=0 after 2 accepts; third held and outputs stable; release OUT_READY -> entries emerge in order with no loss or duplication.
- FLUSH with 2 entries plus a concurrent input -> OUT_VALID=0 next cycle and the input is dropped; assert rst_n=0 mid-stream -> OUT_VALID=0 immediately, ALU_OP_o=0000.
